// File: rtl/regfile_mp_if.sv
// regfile_mp_if: dump-stream bundle for the regfile_mp register file.
//
// Signals:
//   dump_start  request a full register dump (consumer -> register file)
//   dump_ready  consumer accepts the presented word
//   dump_valid  dump word presented
//   dump_addr   index of the presented word
//   dump_data   contents of register dump_addr
//   dump_busy   dump in progress
//   dump_done   one-cycle pulse after the last word is accepted
//
// Modports:
//   master  the register file, which sources the dump stream
//   slave   the consumer (debug capture logic or a testbench)
interface regfile_mp_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;
    logic              dump_done;

    modport master (
        input  dump_start, dump_ready,
        output dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        output dump_start, dump_ready,
        input  dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2-read / 2-write register file with a
// valid/ready dump engine that streams every register out in index order.
//
// Ports:
//   clk, rst                  clock (rising edge) and async active-high reset
//   we0, waddr0, wdata0       write port 0
//   we1, waddr1, wdata1       write port 1 (wins over port 0 on same address)
//   raddr0/rdata0             read port 0, combinational
//   raddr1/rdata1             read port 1, combinational
//   dump                      regfile_mp_if.master dump stream
//
// Optional build macro:
//   REGFILE_BYPASS_EN  when defined, a read whose address matches a legal
//                      write in the same cycle returns the write data
//                      (port 1 wins). The dump path is never bypassed.
//
// Dump FSM:
//   state | meaning
//   IDLE  | waiting for dump_start
//   RUN   | presenting word dump_addr, advancing on dump_valid & dump_ready
//   DONE  | one-cycle dump_done pulse, then back to IDLE
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    regfile_mp_if.master      dump
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic              wr_ok0;
    logic              wr_ok1;

    // An address is "legal" if it is in range and is not the hardwired
    // zero register; the same test gates writes, reads and bypass.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
        return addr_legal(a) ? mem[a] : '0;
    endfunction

    assign wr_ok0 = we0 && addr_legal(waddr0);
    assign wr_ok1 = we1 && addr_legal(waddr1);

    // Storage. Port 1 is tested first so it wins a same-address conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok1 && (waddr1 == ADDR_W'(i))) begin
                    mem[i] <= wdata1;
                end else if (wr_ok0 && (waddr0 == ADDR_W'(i))) begin
                    mem[i] <= wdata0;
                end
            end
        end
    end

    // Read ports.
    always_comb begin
        rdata0 = stored(raddr0);
        rdata1 = stored(raddr1);
`ifdef REGFILE_BYPASS_EN
        // Port 1 checked last so it overrides port 0 when both match.
        if (wr_ok0 && (waddr0 == raddr0)) rdata0 = wdata0;
        if (wr_ok1 && (waddr1 == raddr0)) rdata0 = wdata1;
        if (wr_ok0 && (waddr0 == raddr1)) rdata1 = wdata0;
        if (wr_ok1 && (waddr1 == raddr1)) rdata1 = wdata1;
`endif
    end

    // Dump data is live from storage, so a held word follows writes to it.
    always_comb begin
        dump.dump_data = stored(dump.dump_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            dump.dump_valid <= 1'b0;
            dump.dump_busy  <= 1'b0;
            dump.dump_done  <= 1'b0;
            dump.dump_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dump.dump_done <= 1'b0;
                    if (dump.dump_start) begin
                        state           <= RUN;
                        dump.dump_addr  <= '0;
                        dump.dump_valid <= 1'b1;
                        dump.dump_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (dump.dump_valid && dump.dump_ready) begin
                        if (dump.dump_addr == LAST_IDX) begin
                            state           <= DONE;
                            dump.dump_valid <= 1'b0;
                            dump.dump_busy  <= 1'b0;
                            dump.dump_done  <= 1'b1;
                        end else begin
                            dump.dump_addr <= dump.dump_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    dump.dump_done <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state           <= IDLE;
                    dump.dump_valid <= 1'b0;
                    dump.dump_busy  <= 1'b0;
                    dump.dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (ZERO_REG=1, 32x32).
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge. A reference array models register contents, and a queue of
// expected dump words is filled when a dump is started and drained as the
// DUT hands words over.
`timescale 1ns/1ps
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              we0, we1;
    logic [ADDR_W-1:0] waddr0, waddr1, raddr0, raddr1;
    logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1;

    regfile_mp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

    regfile_mp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(rdata0), .rdata1(rdata1),
        .dump(dif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    word_t             sb_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    int                n_tests = 0;
    int                n_fail  = 0;

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
        return (a == '0) ? '0 : model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the write edge.
    task automatic do_write(input logic e0, input logic [ADDR_W-1:0] a0,
                            input logic [DATA_W-1:0] d0,
                            input logic e1, input logic [ADDR_W-1:0] a1,
                            input logic [DATA_W-1:0] d1);
        we0 = e0; waddr0 = a0; wdata0 = d0;
        we1 = e1; waddr1 = a1; wdata1 = d1;
        @(posedge clk); #1;
        we0 = 1'b0; we1 = 1'b0;
        if (e0 && a0 != '0) model[a0] = d0;
        if (e1 && a1 != '0) model[a1] = d1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr0 = '0; raddr1 = '0;
        dif.dump_start = 1'b0; dif.dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        n_tests++;
        if (dif.dump_valid !== 1'b0 || dif.dump_busy !== 1'b0 ||
            dif.dump_done !== 1'b0 || dif.dump_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_dump_outputs: valid=%b busy=%b done=%b addr=%0d, required all 0",
                     dif.dump_valid, dif.dump_busy, dif.dump_done, dif.dump_addr);
        end
        for (int a = 0; a < DEPTH; a++) begin
            raddr0 = ADDR_W'(a);
            raddr1 = ADDR_W'(DEPTH - 1 - a);
            #1;
            n_tests++;
            if (rdata0 !== '0 || rdata1 !== '0) begin
                n_fail++;
                $display("FAIL reset_read a=%0d: rdata0=%h rdata1=%h, required 0", a, rdata0, rdata1);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dual_write();
        do_write(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 32'h12345678);
        raddr0 = 5'd5; raddr1 = 5'd6;
        @(negedge clk);
        n_tests++;
        if (rdata0 !== 32'hDEADBEEF || rdata0 !== model_rd(5'd5)) begin
            n_fail++;
            $display("FAIL dual_write_r0: got %h, required %h", rdata0, model_rd(5'd5));
        end
        n_tests++;
        if (rdata1 !== 32'h12345678 || rdata1 !== model_rd(5'd6)) begin
            n_fail++;
            $display("FAIL dual_write_r1: got %h, required %h", rdata1, model_rd(5'd6));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_conflict();
        do_write(1'b1, 5'd9, 32'h1111, 1'b1, 5'd9, 32'h2222);
        raddr0 = 5'd9; raddr1 = 5'd9;
        @(negedge clk);
        n_tests++;
        if (rdata0 !== 32'h2222 || rdata1 !== 32'h2222) begin
            n_fail++;
            $display("FAIL conflict: rdata0=%h rdata1=%h, required 00002222", rdata0, rdata1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_reg();
        do_write(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd7, 32'h7777_0007);
        do_write(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF);
        raddr0 = 5'd0; raddr1 = 5'd7;
        @(negedge clk);
        n_tests++;
        if (rdata0 !== '0) begin
            n_fail++;
            $display("FAIL zero_reg_read: got %h, required 0", rdata0);
        end
        n_tests++;
        if (rdata1 !== model_rd(5'd7)) begin
            n_fail++;
            $display("FAIL zero_reg_other_port: got %h, required %h", rdata1, model_rd(5'd7));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp0;
        do_write(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0);
        // Legal write to 3 on port 0, ignored write to 0 on port 1.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF;
        raddr0 = 5'd3; raddr1 = 5'd0;
`ifdef REGFILE_BYPASS_EN
        exp0 = 32'hA5A5;
`else
        exp0 = model_rd(5'd3);
`endif
        @(negedge clk);
        n_tests++;
        if (rdata0 !== exp0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h, required %h", rdata0, exp0);
        end
        n_tests++;
        if (rdata1 !== '0) begin
            n_fail++;
            $display("FAIL bypass_zero_reg: got %h, required 0", rdata1);
        end
        @(posedge clk); #1;
        we0 = 1'b0; we1 = 1'b0;
        model[3] = 32'hA5A5;
        @(negedge clk);
        n_tests++;
        if (rdata0 !== model_rd(5'd3)) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h, required %h", rdata0, model_rd(5'd3));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dump();
        int    accepted = 0;
        int    done_cnt = 0;
        int    last_acc = -1;
        int    done_at  = -1;
        bit    wrote    = 0;
        word_t w;
        for (int k = 0; k < DEPTH; k += 2) begin
            do_write(1'b1, ADDR_W'(k), (k == 0) ? 32'hFFFFFFFF : 32'(k * 3),
                     1'b1, ADDR_W'(k + 1), 32'((k + 1) * 3));
        end
        dif.dump_start = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            w.addr = ADDR_W'(k);
            w.data = model_rd(ADDR_W'(k));
            sb_q.push_back(w);
        end
        @(posedge clk); #1;
        dif.dump_start = 1'b0;
        n_tests++;
        if (dif.dump_busy !== 1'b1 || dif.dump_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dump_start: busy=%b valid=%b, required 1 1", dif.dump_busy, dif.dump_valid);
        end
        for (int c = 0; c < 100; c++) begin
            dif.dump_ready = (c % 2 == 0);
            dif.dump_start = (c == 5);
            if (accepted == 10 && !wrote) begin
                we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'hCAFE0014;
                model[20] = 32'hCAFE0014;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (sb_q[i].addr == 5'd20) begin
                        w = sb_q[i];
                        w.data = 32'hCAFE0014;
                        sb_q[i] = w;
                    end
                end
                wrote = 1;
            end
            @(negedge clk);
            if (dif.dump_valid && dif.dump_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dump_extra_word: addr=%0d data=%h, required no word", dif.dump_addr, dif.dump_data);
                end else begin
                    w = sb_q.pop_front();
                    if (dif.dump_addr !== w.addr || dif.dump_data !== w.data) begin
                        n_fail++;
                        $display("FAIL dump_word: addr=%0d data=%h, required addr=%0d data=%h",
                                 dif.dump_addr, dif.dump_data, w.addr, w.data);
                    end
                end
                accepted++;
                last_acc = c;
            end
            if (dif.dump_done) begin
                done_cnt++;
                done_at = c;
                n_tests++;
                if (dif.dump_valid !== 1'b0 || dif.dump_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dump_done_state: valid=%b busy=%b, required 0 0", dif.dump_valid, dif.dump_busy);
                end
                dif.dump_start = 1'b1;  // must be ignored in DONE
            end
            @(posedge clk); #1;
            we0 = 1'b0;
            dif.dump_start = 1'b0;
        end
        n_tests++;
        if (accepted != DEPTH || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL dump_count: accepted=%0d left=%0d, required %0d and 0", accepted, sb_q.size(), DEPTH);
        end
        n_tests++;
        if (done_cnt != 1 || done_at != last_acc + 1) begin
            n_fail++;
            $display("FAIL dump_done_pulse: pulses=%0d at=%0d, required 1 at %0d", done_cnt, done_at, last_acc + 1);
        end
        n_tests++;
        if (dif.dump_valid !== 1'b0 || dif.dump_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_idle_after: valid=%b busy=%b, required 0 0", dif.dump_valid, dif.dump_busy);
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid_dump();
        int done_cnt = 0;
        int valid_cnt = 0;
        do_write(1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 32'h0);
        dif.dump_start = 1'b1;
        dif.dump_ready = 1'b1;
        @(posedge clk); #1;
        dif.dump_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        dif.dump_ready = 1'b0;
        rst = 1'b1;
        raddr0 = 5'd5;
        #1;
        model_clear();
        n_tests++;
        if (dif.dump_busy !== 1'b0 || dif.dump_valid !== 1'b0 || dif.dump_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_dump: busy=%b valid=%b addr=%0d, required 0 0 0",
                     dif.dump_busy, dif.dump_valid, dif.dump_addr);
        end
        n_tests++;
        if (rdata0 !== model_rd(5'd5)) begin
            n_fail++;
            $display("FAIL reset_mid_dump_clear: got %h, required %h", rdata0, model_rd(5'd5));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dif.dump_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dif.dump_done) done_cnt++;
            if (dif.dump_valid) valid_cnt++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (done_cnt != 0 || valid_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_mid_dump_quiet: done=%0d valid=%0d cycles, required 0 0", done_cnt, valid_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_conflict();
        test_zero_reg();
        test_bypass();
        test_dump();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised 2-read/2-write register file; next generation of the processor's register bank.
- Width and depth are parameters. Adds asynchronous reset, an optional hardwired zero register, and defined priority when both write ports target the same address.
- Replaces simulation-only file dumps with a synthesizable valid/ready dump engine, which streams every register out for debug or testbench capture.
- Sits between decode (read addresses) and writeback (two write ports) in the datapath.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers.
- ADDR_W, 5, address width; must equal clog2(DEPTH).
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- raddr0  in  ADDR_W  read address, port 0.
- raddr1  in  ADDR_W  read address, port 1.
- rdata0  out  DATA_W  read data, port 0 (combinational).
- rdata1  out  DATA_W  read data, port 1 (combinational).
- dump_start  in  1  request a full dump.
- dump_ready  in  1  consumer accepts the current dump word.
- dump_valid  out  1  dump word presented.
- dump_addr  out  ADDR_W  index of the presented word.
- dump_data  out  DATA_W  contents of register dump_addr.
- dump_busy  out  1  dump in progress.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset:
  - One clock, clk; reset rst is asynchronous and active-high.
  - On rst=1, all DEPTH registers clear to 0, the dump FSM enters IDLE, and dump_valid, dump_busy, dump_done and dump_addr are 0.
  - Reset asserted mid-dump aborts the dump; no dump_done pulse.
- Reads:
  - rdata = array[raddr], combinational, zero latency.
  - raddr >= DEPTH returns 0.
  - With ZERO_REG=1, raddr=0 returns 0.
- Writes:
  - Take effect at the rising edge when weN=1 and visible on reads the following cycle.
  - waddr >= DEPTH is ignored.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Write conflict: if we0 and we1 are both 1 and waddr0==waddr1, port 1 data is stored and port 0 is dropped. Different addresses both write in the same cycle.
- Dump FSM states: IDLE, RUN, DONE.
  - IDLE: dump_start=1 leads to RUN with idx=0; dump_busy=1 from the next cycle. dump_start is ignored in RUN and DONE.
  - RUN: dump_valid=1, dump_addr=idx, dump_data=array[idx] live (ZERO_REG rule applies).
  - On dump_valid & dump_ready: if idx==DEPTH-1, go to DONE; otherwise idx+1.
  - While dump_ready=0: dump_addr holds, and dump_data tracks any write to that register.
  - DONE: lasts one cycle with dump_done=1, dump_valid=0, dump_busy=0, then IDLE. dump_start during DONE is ignored.
  - Register writes proceed normally during a dump. A word reflects array contents in the cycle it is accepted.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose raddr matches an active, legal write address in the same cycle returns that write data, with port 1 winning if both ports match. No bypass for ignored writes (address 0 with ZERO_REG=1, out-of-range). The dump path is never bypassed.
- Undefined: reads return only stored contents; the new value appears the next cycle.

Test Plan:
- Reset then read all addresses: every rdata=0. Assert rst mid-dump: dump_busy=0 immediately, no dump_done pulse.
- Write wdata0=0xDEADBEEF to 5 and wdata1=0x12345678 to 6 in one cycle: next cycle raddr0=5 gives 0xDEADBEEF and raddr1=6 gives 0x12345678.
- Conflict: we0, we1 both to address 9 with 0x1111 and 0x2222: register 9 reads 0x2222.
- ZERO_REG=1: write 0xFFFFFFFF to address 0: rdata reads 0, and the dump word for address 0 is 0.
- Bypass: same-cycle write 0xA5A5 to 3 with raddr0=3. With REGFILE_BYPASS_EN, rdata0=0xA5A5 that cycle; without it, the old value that cycle and 0xA5A5 next cycle.
- Dump: preload reg k=k*3, pulse dump_start, toggle dump_ready 1,0,1,… Expect exactly DEPTH accepted words with addr 0..DEPTH-1 in order and data k*3, then dump_done=1 for one cycle. A mid-dump write to a not-yet-accepted register shows the new value.
